// File: rtl/mem_ctrl.sv
// Request-driven memory controller: single-word read/write and ascending block copy
// against a synchronous memory with one-cycle registered read data.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_dst,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_CAP = 3'd2,
    S_WR     = 3'd3,
    S_CP_RD  = 3'd4,
    S_CP_WR  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CP = 2'b10;
  localparam logic [1:0] OP_RS = 2'b11;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_dst;
  logic [ADDR_WIDTH-1:0]   r_len;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    w_accept;
  logic                    w_last_word;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_last_word = (r_idx == (r_len - ADDR_WIDTH'(1)));

  // State, captured request fields, copy index and read-result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_addr  <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_dst   <= req_dst;
        r_len   <= req_len;
        r_wdata <= req_wdata;
        r_idx   <= '0;
      end
      if (r_state == S_CP_WR) begin
        r_idx <= r_idx + ADDR_WIDTH'(1);
      end
      if (r_state == S_RD_CAP) begin
        r_rdata <= mem_out;
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_RD:   w_next_state = S_RD;
            OP_WR:   w_next_state = S_WR;
            OP_CP:   w_next_state = (req_len != '0) ? S_CP_RD : S_DONE;
            default: w_next_state = S_DONE;
          endcase
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD:     w_next_state = S_RD_CAP;
      S_RD_CAP: w_next_state = S_DONE;
      S_WR:     w_next_state = S_DONE;
      S_CP_RD:  w_next_state = S_CP_WR;
      S_CP_WR:  w_next_state = w_last_word ? S_DONE : S_CP_RD;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Memory port drive; copy data is forwarded straight from the registered read port
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (r_state)
      S_RD: begin
        mem_addr = r_addr;
      end
      S_WR: begin
        mem_we   = 1'b1;
        mem_addr = r_addr;
        mem_data = r_wdata;
      end
      S_CP_RD: begin
        mem_addr = r_addr + r_idx;
      end
      S_CP_WR: begin
        mem_we   = 1'b1;
        mem_addr = r_dst + r_idx;
        mem_data = mem_out;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
      end
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_err   = (r_state == S_DONE) && (r_op == OP_RS);
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: 64x16 synchronous memory, directed scenarios
// and randomized traffic against an array-based reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [5:0]  req_addr = 6'd0;
  logic [5:0]  req_dst = 6'd0;
  logic [5:0]  req_len = 6'd0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_out;

  logic [15:0] mem [64];
  logic        mem_init = 1'b1;
  logic [15:0] ref_mem [64];
  logic [15:0] ref_last;
  int          n_checks = 0;
  int          n_pass = 0;

  mem_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Synchronous memory with registered read port (read-before-write)
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
      mem[8] <= 16'h7101;
      mem[9] <= 16'h8101;
      mem_out <= 16'h0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_out <= mem[mem_addr];
    end
  end

  // Reference model: applies one request to ref_mem and predicts the response
  task automatic ref_apply(input logic [1:0] op, input logic [5:0] a, input logic [5:0] d,
                           input logic [5:0] l, input logic [15:0] wd, output int cyc,
                           output logic [15:0] rd, output logic err, output int we);
    err = 1'b0;
    we  = 0;
    cyc = 1;
    case (op)
      2'b00: begin ref_last = ref_mem[a]; cyc = 3; end
      2'b01: begin ref_mem[a] = wd; cyc = 2; we = 1; end
      2'b10: begin
        for (int i = 0; i < int'(l); i++)
          ref_mem[(int'(d) + i) % 64] = ref_mem[(int'(a) + i) % 64];
        we  = int'(l);
        cyc = (l == 6'd0) ? 1 : 2 * int'(l) + 1;
      end
      default: begin err = 1'b1; cyc = 1; end
    endcase
    rd = ref_last;
  endtask

  // Issues one request, injects ignored noise while busy, and observes the response
  task automatic do_req(input logic [1:0] op, input logic [5:0] a, input logic [5:0] d,
                        input logic [5:0] l, input logic [15:0] wd, output int cyc,
                        output logic [15:0] rd, output logic err, output int we_cnt,
                        output int bad, output logic [5:0] wa0, output logic [5:0] wa1,
                        output logic rdy_ok);
    cyc = -1; rd = 16'h0; err = 1'b0; we_cnt = 0; bad = 0; wa0 = 6'd0; wa1 = 6'd0;
    @(negedge clk);
    rdy_ok = req_ready;
    req_valid = 1'b1; req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (mem_we) begin
        if (we_cnt == 0) wa0 = mem_addr;
        if (we_cnt == 1) wa1 = mem_addr;
        we_cnt++;
      end else if (mem_data !== 16'h0) begin
        bad++;
      end
      if (req_ready) bad++;
      if (rsp_valid) begin
        cyc = k; rd = rsp_rdata; err = rsp_err;
        if (mem_addr !== 6'd0) bad++;
        req_valid = 1'b0;
        break;
      end
      req_valid = 1'($urandom); req_op = 2'($urandom); req_addr = 6'($urandom);
      req_dst = 6'($urandom); req_len = 6'($urandom); req_wdata = 16'($urandom);
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid || !req_ready) bad++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0}) begin
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b we=%b rd=%h a=%h d=%h, want 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_data);
    end else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    int c, ec, w, ew, b; logic [15:0] r, er; logic e, ee, ok; logic [5:0] x0, x1;
    ref_apply(2'b00, 6'd8, 6'd0, 6'd0, 16'h0, ec, er, ee, ew);
    do_req(2'b00, 6'd8, 6'd0, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 3 || r !== 16'h7101 || e !== 1'b0 || w !== 0 || b !== 0 || ok !== 1'b1)
      $display("FAIL read8: got cyc=%0d rd=%h err=%b we=%0d bad=%0d rdy=%b, want 3 7101 0 0 0 1", c, r, e, w, b, ok);
    else n_pass++;
    n_checks++;
    if (r !== er) $display("FAIL read8_model: got %h want %h", r, er); else n_pass++;
  endtask

  task automatic test_write();
    int c, ec, w, ew, b; logic [15:0] r, er; logic e, ee, ok; logic [5:0] x0, x1;
    ref_apply(2'b01, 6'd20, 6'd0, 6'd0, 16'hBEEF, ec, er, ee, ew);
    do_req(2'b01, 6'd20, 6'd0, 6'd0, 16'hBEEF, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 2 || w !== 1 || x0 !== 6'd20 || e !== 1'b0 || b !== 0 || r !== er)
      $display("FAIL write20: got cyc=%0d we=%0d wa=%0d err=%b bad=%0d rd=%h, want 2 1 20 0 0 %h", c, w, x0, e, b, r, er);
    else n_pass++;
    ref_apply(2'b00, 6'd20, 6'd0, 6'd0, 16'h0, ec, er, ee, ew);
    do_req(2'b00, 6'd20, 6'd0, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 3 || r !== 16'hBEEF || er !== 16'hBEEF)
      $display("FAIL readback20: got cyc=%0d rd=%h, want 3 BEEF", c, r);
    else n_pass++;
  endtask

  task automatic test_copy();
    int c, ec, w, ew, b; logic [15:0] r, er; logic e, ee, ok; logic [5:0] x0, x1;
    ref_apply(2'b10, 6'd8, 6'd30, 6'd2, 16'h0, ec, er, ee, ew);
    do_req(2'b10, 6'd8, 6'd30, 6'd2, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 5 || w !== 2 || x0 !== 6'd30 || x1 !== 6'd31 || e !== 1'b0 || b !== 0)
      $display("FAIL copy8to30: got cyc=%0d we=%0d wa=%0d,%0d err=%b bad=%0d, want 5 2 30,31 0 0", c, w, x0, x1, e, b);
    else n_pass++;
    do_req(2'b00, 6'd30, 6'd0, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    ref_apply(2'b00, 6'd30, 6'd0, 6'd0, 16'h0, ec, er, ee, ew);
    n_checks++;
    if (r !== 16'h7101) $display("FAIL copy_mem30: got %h want 7101", r); else n_pass++;
    do_req(2'b00, 6'd31, 6'd0, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    ref_apply(2'b00, 6'd31, 6'd0, 6'd0, 16'h0, ec, er, ee, ew);
    n_checks++;
    if (r !== 16'h8101) $display("FAIL copy_mem31: got %h want 8101", r); else n_pass++;
  endtask

  task automatic test_wrap();
    int c, ec, w, ew, b; logic [15:0] r, er; logic e, ee, ok; logic [5:0] x0, x1;
    do_req(2'b01, 6'd63, 6'd0, 6'd0, 16'h1234, c, r, e, w, b, x0, x1, ok);
    ref_apply(2'b01, 6'd63, 6'd0, 6'd0, 16'h1234, ec, er, ee, ew);
    do_req(2'b01, 6'd0, 6'd0, 6'd0, 16'h5678, c, r, e, w, b, x0, x1, ok);
    ref_apply(2'b01, 6'd0, 6'd0, 6'd0, 16'h5678, ec, er, ee, ew);
    ref_apply(2'b10, 6'd63, 6'd62, 6'd2, 16'h0, ec, er, ee, ew);
    do_req(2'b10, 6'd63, 6'd62, 6'd2, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 5 || w !== 2 || x0 !== 6'd62 || x1 !== 6'd63 || b !== 0)
      $display("FAIL wrap_seq: got cyc=%0d we=%0d wa=%0d,%0d bad=%0d, want 5 2 62,63 0", c, w, x0, x1, b);
    else n_pass++;
    n_checks++;
    if (mem[62] !== 16'h1234 || mem[63] !== 16'h5678 || ref_mem[63] !== 16'h5678)
      $display("FAIL wrap_data: got m62=%h m63=%h, want 1234 5678", mem[62], mem[63]);
    else n_pass++;
  endtask

  task automatic test_edge();
    int c, ec, w, ew, b; logic [15:0] r, er; logic e, ee, ok; logic [5:0] x0, x1;
    ref_apply(2'b11, 6'd5, 6'd6, 6'd7, 16'hAAAA, ec, er, ee, ew);
    do_req(2'b11, 6'd5, 6'd6, 6'd7, 16'hAAAA, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 1 || e !== 1'b1 || w !== 0 || b !== 0 || r !== er)
      $display("FAIL reserved_op: got cyc=%0d err=%b we=%0d bad=%0d rd=%h, want 1 1 0 0 %h", c, e, w, b, r, er);
    else n_pass++;
    ref_apply(2'b10, 6'd8, 6'd50, 6'd0, 16'h0, ec, er, ee, ew);
    do_req(2'b10, 6'd8, 6'd50, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 1 || e !== 1'b0 || w !== 0 || b !== 0)
      $display("FAIL copy_len0: got cyc=%0d err=%b we=%0d bad=%0d, want 1 0 0 0", c, e, w, b);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int c, ec, w, ew, b, seen; logic [15:0] r, er, old40; logic e, ee, ok; logic [5:0] x0, x1;
    old40 = ref_mem[40];
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 6'd8; req_dst = 6'd40; req_len = 6'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 6'd40)
      $display("FAIL abort_in_cpwr: got we=%b addr=%0d, want 1 40", mem_we, mem_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0})
      $display("FAIL abort_outputs: got rdy=%b vld=%b err=%b we=%b rd=%h a=%h d=%h, want 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_data);
    else n_pass++;
    ref_last = 16'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (rsp_valid || mem_we) seen++;
    end
    n_checks++;
    if (seen !== 0 || (mem[40] !== old40 && mem[40] !== ref_mem[8]) ||
        mem[41] !== ref_mem[41] || mem[42] !== ref_mem[42] || mem[43] !== ref_mem[43])
      $display("FAIL abort_effects: got activity=%0d m40..43=%h %h %h %h, want 0 and only m40 may change",
               seen, mem[40], mem[41], mem[42], mem[43]);
    else n_pass++;
    ref_mem[40] = mem[40];
    ref_apply(2'b00, 6'd9, 6'd0, 6'd0, 16'h0, ec, er, ee, ew);
    do_req(2'b00, 6'd9, 6'd0, 6'd0, 16'h0, c, r, e, w, b, x0, x1, ok);
    n_checks++;
    if (c !== 3 || r !== 16'h8101 || ok !== 1'b1 || b !== 0)
      $display("FAIL abort_then_read: got cyc=%0d rd=%h rdy=%b bad=%0d, want 3 8101 1 0", c, r, ok, b);
    else n_pass++;
  endtask

  task automatic test_random();
    int c, ec, w, ew, b; logic [15:0] r, er, wd; logic e, ee, ok; logic [5:0] x0, x1, a, d, l;
    logic [1:0] op;
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom); a = 6'($urandom); d = 6'($urandom); wd = 16'($urandom);
      l = 6'($urandom_range(0, 20));
      if (t % 8 == 0) d = a + 6'($urandom_range(1, 3));
      ref_apply(op, a, d, l, wd, ec, er, ee, ew);
      do_req(op, a, d, l, wd, c, r, e, w, b, x0, x1, ok);
      n_checks++;
      if (c !== ec || r !== er || e !== ee || w !== ew || b !== 0 || ok !== 1'b1)
        $display("FAIL rand_%0d op=%0d: got cyc=%0d rd=%h err=%b we=%0d bad=%0d, want %0d %h %b %0d 0",
                 t, op, c, r, e, w, b, ec, er, ee, ew);
      else n_pass++;
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) $display("FAIL final_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;
    ref_mem[8] = 16'h7101;
    ref_mem[9] = 16'h8101;
    ref_last = 16'h0;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_copy();
    test_wrap();
    test_edge();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
